// File: rtl/line_scanout_pkg.sv
// Shared types and constants for the sprite line-buffer scan-out path.
// The optional opaque-pixel statistics are enabled with LINE_SCANOUT_STATS_EN.
package line_pkg;

    // Visible columns per line and the word that marks a line-buffer entry empty.
    localparam int unsigned H_ACTIVE         = 640;
    localparam logic [15:0] TRANSPARENT_WORD = 16'h8000;

    // One line-buffer entry: transparent flag on top, then RGB555.
    typedef struct packed {
        logic       transparent;
        logic [4:0] r5;
        logic [4:0] g5;
        logic [4:0] b5;
    } pixel_t;

    // Scan-out controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Transparent entries show the background colour, others show their own colour.
    function automatic logic [14:0] pick_rgb(input pixel_t px, input logic [14:0] bg);
        return px.transparent ? bg : {px.r5, px.g5, px.b5};
    endfunction

endpackage

// File: rtl/line_scanout_if.sv
// Line-buffer port bundle: read side plus the clear-after-read write side.
// master = scan-out controller, slave = line-buffer RAM.
interface line_scanout_if;
    logic        lb_rd_buf;
    logic [9:0]  lb_rd_addr;
    logic [15:0] lb_q;
    logic [9:0]  lb_clr_addr;
    logic [15:0] lb_clr_data;
    logic        lb_clr_wren;

    modport master (
        output lb_rd_buf,
        output lb_rd_addr,
        output lb_clr_addr,
        output lb_clr_data,
        output lb_clr_wren,
        input  lb_q
    );

    modport slave (
        input  lb_rd_buf,
        input  lb_rd_addr,
        input  lb_clr_addr,
        input  lb_clr_data,
        input  lb_clr_wren,
        output lb_q
    );
endinterface

// File: rtl/line_scanout_rgb555_expand.sv
// Combinational RGB555 -> RGB888 expansion; the top bits of each channel are
// replicated into the low bits so full-scale 5-bit maps to full-scale 8-bit.
module rgb555_expand (
    input  logic [14:0] rgb555_i,
    output logic [7:0]  r8_o,
    output logic [7:0]  g8_o,
    output logic [7:0]  b8_o
);
    assign r8_o = {rgb555_i[14:10], rgb555_i[14:12]};
    assign g8_o = {rgb555_i[9:5],   rgb555_i[9:7]};
    assign b8_o = {rgb555_i[4:0],   rgb555_i[4:2]};
endmodule

// File: rtl/line_scanout.sv
// Read side of the double-banked sprite line buffer: swaps banks per line,
// streams the display bank out as RGB888 (3-cycle latency from pix_en), clears
// each consumed entry back to transparent and kicks the drawers for the next line.
// Define LINE_SCANOUT_STATS_EN to add the opaque_cnt statistics output.
module line_scanout #(
    parameter int unsigned H_ACTIVE = line_pkg::H_ACTIVE,
    parameter logic [15:0] CLR_WORD = line_pkg::TRANSPARENT_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic                 pix_en,
    input  logic [9:0]           hcount,
    input  logic [14:0]          bg_color,
    line_scanout_if.master       lb,
    output logic                 draw_buf,
    output logic                 draw_go,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_de,
    output logic                 underrun
`ifdef LINE_SCANOUT_STATS_EN
    ,
    output logic [9:0]           opaque_cnt
`endif
);
    import line_pkg::*;

    localparam logic [10:0] H_END    = 11'(H_ACTIVE);
    localparam logic [9:0]  LAST_COL = 10'(H_ACTIVE - 1);

    state_t      state_q;
    logic        rd_buf_q;
    logic        go_pend_q;
    logic        draw_go_q;
    logic        underrun_q;
    logic        drain_cnt_q;
    logic [9:0]  rd_addr_q;
    logic        s1_vld_q;
    logic        s2_vld_q;
    logic [9:0]  s2_col_q;
    logic        vga_de_q;
    logic [7:0]  vga_r_q;
    logic [7:0]  vga_g_q;
    logic [7:0]  vga_b_q;

    logic        rd_hit;
    logic        pix_live;
    pixel_t      px;
    logic [14:0] rgb15;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;

    // A column read is issued only for visible columns.
    assign rd_hit   = pix_en && ({1'b0, hcount} < H_END);
    // The entry on lb_q is live unless a new line is flushing the pipeline.
    assign pix_live = s2_vld_q && !line_start;

    assign px    = pixel_t'(lb.lb_q);
    assign rgb15 = pick_rgb(px, bg_color);

    rgb555_expand u_expand (
        .rgb555_i (rgb15),
        .r8_o     (r8),
        .g8_o     (g8),
        .b8_o     (b8)
    );

    // Controller FSM: bank swap, draw kick, read issue and underrun detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_buf_q    <= 1'b0;
            go_pend_q   <= 1'b0;
            draw_go_q   <= 1'b0;
            underrun_q  <= 1'b0;
            drain_cnt_q <= 1'b0;
            rd_addr_q   <= '0;
            s1_vld_q    <= 1'b0;
        end else begin
            go_pend_q <= line_start;
            draw_go_q <= go_pend_q;
            s1_vld_q  <= 1'b0;
            if (line_start) begin
                // A new line always wins; anything in flight is dropped.
                rd_buf_q <= ~rd_buf_q;
                state_q  <= SCAN;
                if (state_q == SCAN) begin
                    underrun_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    SCAN: begin
                        if (rd_hit) begin
                            rd_addr_q <= hcount;
                            s1_vld_q  <= 1'b1;
                            if (hcount == LAST_COL) begin
                                state_q     <= DRAIN;
                                drain_cnt_q <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        // Two cycles lets the last read reach lb_q.
                        if (drain_cnt_q) begin
                            state_q <= IDLE;
                        end
                        drain_cnt_q <= ~drain_cnt_q;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Data pipeline: RAM-latency stage, then registered colour output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld_q <= 1'b0;
            s2_col_q <= '0;
            vga_de_q <= 1'b0;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q && !line_start;
            s2_col_q <= rd_addr_q;
            vga_de_q <= pix_live;
            vga_r_q  <= pix_live ? r8 : 8'h00;
            vga_g_q  <= pix_live ? g8 : 8'h00;
            vga_b_q  <= pix_live ? b8 : 8'h00;
        end
    end

    // The entry whose data is on lb_q this cycle is cleared in the same cycle.
    assign lb.lb_rd_buf   = rd_buf_q;
    assign lb.lb_rd_addr  = rd_addr_q;
    assign lb.lb_clr_addr = s2_col_q;
    assign lb.lb_clr_data = CLR_WORD;
    assign lb.lb_clr_wren = pix_live;

    assign draw_buf = ~rd_buf_q;
    assign draw_go  = draw_go_q;
    assign vga_r    = vga_r_q;
    assign vga_g    = vga_g_q;
    assign vga_b    = vga_b_q;
    assign vga_de   = vga_de_q;
    assign underrun = underrun_q;

`ifdef LINE_SCANOUT_STATS_EN
    logic [9:0] opaque_run_q;
    logic [9:0] opaque_cnt_q;
    logic [9:0] opaque_inc;
    logic       drain_end;

    assign opaque_inc = 10'(pix_live && !px.transparent);
    assign drain_end  = (state_q == DRAIN) && drain_cnt_q && !line_start;

    // Running opaque count per line, published when the line finishes draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opaque_run_q <= '0;
            opaque_cnt_q <= '0;
        end else if (line_start) begin
            opaque_run_q <= '0;
        end else begin
            opaque_run_q <= opaque_run_q + opaque_inc;
            if (drain_end) begin
                opaque_cnt_q <= opaque_run_q + opaque_inc;
            end
        end
    end

    assign opaque_cnt = opaque_cnt_q;
`else
    // Statistics disabled: no counter and no opaque_cnt port.
`endif

endmodule

// File: tb/tb_line_scanout.sv
// Scoreboard bench for line_scanout: stimulus pushes expected pixels and
// clear addresses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_line_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  hcount = '0;
    logic [14:0] bg_color = 15'h001F;
    logic        draw_buf;
    logic        draw_go;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_de;
    logic        underrun;
`ifdef LINE_SCANOUT_STATS_EN
    logic [9:0]  opaque_cnt;
`endif

    line_scanout_if lb_bus ();

    line_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .pix_en     (pix_en),
        .hcount     (hcount),
        .bg_color   (bg_color),
        .lb         (lb_bus),
        .draw_buf   (draw_buf),
        .draw_go    (draw_go),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_de     (vga_de),
        .underrun   (underrun)
`ifdef LINE_SCANOUT_STATS_EN
        ,
        .opaque_cnt (opaque_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Line-buffer RAM model with registered read and preload port.
    logic [15:0] mem [0:1][0:639];
    logic        pl_en = 1'b0;
    logic        pl_bank = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 640; a++)
                    mem[b][a] <= 16'h8000;
            lb_bus.lb_q <= 16'h0000;
        end else begin
            lb_bus.lb_q <= mem[lb_bus.lb_rd_buf][lb_bus.lb_rd_addr];
            if (lb_bus.lb_clr_wren)
                mem[lb_bus.lb_rd_buf][lb_bus.lb_clr_addr] <= lb_bus.lb_clr_data;
            if (pl_en)
                mem[pl_bank][pl_addr] <= pl_data;
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad = 0;
    int de_cnt = 0;
    int first_de = -1;
    int first_pe = -1;
    logic [23:0] pix_q [$];
    logic [9:0]  clr_q [$];
    logic [23:0] exp_px [0:639];
    logic [15:0] w_tab [0:3] = '{16'h7C00, 16'h03E0, 16'h4210, 16'h0000};
    logic [23:0] e_tab [0:3] = '{24'hFF0000, 24'h00FF00, 24'h848484, 24'h000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every emerging pixel and every clear must match the scoreboard.
    initial begin
        logic [23:0] ep;
        logic [9:0]  ec;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (vga_de) begin
                    de_cnt++;
                    if (first_de < 0) first_de = cyc_cnt;
                    if (pix_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL vga_extra: got rgb %02h%02h%02h expected no pixel", vga_r, vga_g, vga_b);
                    end else begin
                        ep = pix_q.pop_front();
                        check("vga_rgb", {8'h00, vga_r, vga_g, vga_b}, {8'h00, ep});
                    end
                end
                if (lb_bus.lb_clr_wren) begin
                    check("clr_data", {16'h0, lb_bus.lb_clr_data}, 32'h8000);
                    if (clr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL clr_extra: got clear of col %0d expected none", lb_bus.lb_clr_addr);
                    end else begin
                        ec = clr_q.pop_front();
                        check("clr_addr", {22'h0, lb_bus.lb_clr_addr}, {22'h0, ec});
                    end
                end
            end
        end
    end

    task automatic cyc(input logic ls, input logic pe, input logic [9:0] hc);
        line_start = ls;
        pix_en     = pe;
        hcount     = hc;
        @(posedge clk); #1;
        line_start = 1'b0;
        pix_en     = 1'b0;
    endtask

    task automatic poke(input logic bank, input logic [9:0] addr, input logic [15:0] data);
        pl_en = 1'b1; pl_bank = bank; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic expect_bg();
        for (int c = 0; c < 640; c++) exp_px[c] = 24'h0000FF;
    endtask

    task automatic start_line(input logic exp_bank);
        cyc(1'b1, 1'b0, 10'd0);
        check("rd_buf", {31'h0, lb_bus.lb_rd_buf}, {31'h0, exp_bank});
        check("draw_buf", {31'h0, draw_buf}, {31'h0, !exp_bank});
        check("draw_go_early", {31'h0, draw_go}, 32'h0);
        cyc(1'b0, 1'b0, 10'd0);
        check("draw_go", {31'h0, draw_go}, 32'h1);
        cyc(1'b0, 1'b0, 10'd0);
        check("draw_go_end", {31'h0, draw_go}, 32'h0);
    endtask

    // mode 0: pix_en every cycle; mode 1: every other cycle plus hcount=700 strobes.
    task automatic run_line(input int id, input int mode);
        de_cnt = 0; first_de = -1; first_pe = -1;
        for (int c = 0; c < 640; c++) begin
            pix_q.push_back(exp_px[c]);
            clr_q.push_back(10'(c));
            if (first_pe < 0) first_pe = cyc_cnt;
            cyc(1'b0, 1'b1, 10'(c));
            if (mode == 1) begin
                if (c % 2 == 0) cyc(1'b0, 1'b0, 10'd0);
                else            cyc(1'b0, 1'b1, 10'd700);
            end
        end
        repeat (6) cyc(1'b0, 1'b0, 10'd0);
        check("de_count", de_cnt, 640);
        check("latency", first_de - first_pe, 3);
        check("pix_q_empty", pix_q.size(), 0);
        check("clr_q_empty", clr_q.size(), 0);
        $display("line %0d: bank=%0d mode=%0d de=%0d underrun=%0d", id, lb_bus.lb_rd_buf, mode, de_cnt, underrun);
    endtask

    initial begin
        // Reset state.
        repeat (4) @(posedge clk);
        #1;
        check("rst_rd_buf", {31'h0, lb_bus.lb_rd_buf}, 32'h0);
        check("rst_draw_buf", {31'h0, draw_buf}, 32'h1);
        check("rst_draw_go", {31'h0, draw_go}, 32'h0);
        check("rst_vga_de", {31'h0, vga_de}, 32'h0);
        check("rst_vga_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        check("rst_clr_wren", {31'h0, lb_bus.lb_clr_wren}, 32'h0);
        check("rst_clr_data", {16'h0, lb_bus.lb_clr_data}, 32'h8000);
        check("rst_rd_addr", {22'h0, lb_bus.lb_rd_addr}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Line 1: bank 1, red at col 5, blue background elsewhere.
        poke(1'b1, 10'd5, 16'h7C00);
        expect_bg();
        exp_px[5] = 24'hFF0000;
        start_line(1'b1);
        run_line(1, 0);
`ifdef LINE_SCANOUT_STATS_EN
        check("opaque_cnt_l1", {22'h0, opaque_cnt}, 32'd1);
`endif

        // Line 2: bank 0, sparse strobes with out-of-range columns.
        expect_bg();
        start_line(1'b0);
        run_line(2, 1);
`ifdef LINE_SCANOUT_STATS_EN
        check("opaque_cnt_l2", {22'h0, opaque_cnt}, 32'd0);
`endif

        // Line 3: bank 1 again, must be fully cleared (col 5 now background).
        expect_bg();
        start_line(1'b1);
        run_line(3, 0);

        // Line 4: bank 0 with 37 opaque entries of mixed colours.
        expect_bg();
        for (int i = 0; i < 37; i++) begin
            poke(1'b0, 10'(i), w_tab[i % 4]);
            exp_px[i] = e_tab[i % 4];
        end
        start_line(1'b0);
        run_line(4, 0);
        check("underrun_clean", {31'h0, underrun}, 32'h0);
`ifdef LINE_SCANOUT_STATS_EN
        check("opaque_cnt_37", {22'h0, opaque_cnt}, 32'd37);
`endif

        // Line 5: bank 1 cut short by line_start at hcount=300.
        expect_bg();
        start_line(1'b1);
        de_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (c < 298) begin
                pix_q.push_back(exp_px[c]);
                clr_q.push_back(10'(c));
            end
            cyc(1'b0, 1'b1, 10'(c));
        end
        cyc(1'b1, 1'b1, 10'd300);
        check("cut_rd_buf", {31'h0, lb_bus.lb_rd_buf}, 32'h0);
        check("cut_underrun", {31'h0, underrun}, 32'h1);
        check("cut_draw_go_early", {31'h0, draw_go}, 32'h0);
        cyc(1'b0, 1'b0, 10'd0);
        check("cut_draw_go", {31'h0, draw_go}, 32'h1);
        repeat (4) cyc(1'b0, 1'b0, 10'd0);
        check("cut_de_count", de_cnt, 298);
        check("cut_pix_q_empty", pix_q.size(), 0);
        check("cut_clr_q_empty", clr_q.size(), 0);
        $display("line 5: cut at 300, de=%0d underrun=%0d", de_cnt, underrun);

        // Line 6: the line started above runs on bank 0; underrun must stay set.
        expect_bg();
        run_line(6, 0);
        check("underrun_sticky", {31'h0, underrun}, 32'h1);
        check("final_rd_buf", {31'h0, lb_bus.lb_rd_buf}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion expected finish before 2ms");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
